seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and completes in a single cycle.
module seq_divider #(
  parameter int unsigned XLEN = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            ready,
  output logic            done,
  output logic            dz,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERATE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] dvd;        // captured dividend, consumed MSB first
  logic [XLEN-1:0] dvs;        // captured divisor
  logic [XLEN-1:0] prem;       // partial remainder
  logic [XLEN-1:0] quo;        // quotient under construction
  logic [CW-1:0]   count;      // steps still to perform

  logic            last_step;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            borrow;
  logic [XLEN-1:0] prem_next;
  logic [XLEN-1:0] quo_next;

  assign last_step = (count == CW'(1));

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value is below twice the divisor and the sign bit of an
  // XLEN+1-bit difference is a reliable borrow indicator.
  always_comb begin
    shifted   = {prem, dvd[XLEN-1]};
    diff      = shifted - {1'b0, dvs};
    borrow    = diff[XLEN];
    prem_next = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_next  = {quo[XLEN-2:0], ~borrow};
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = (divisor == '0) ? DONE : OPERATE;
      end
      OPERATE: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      quo       <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dz        <= 1'b1;
            end else begin
              dvd   <= dividend;
              dvs   <= divisor;
              prem  <= '0;
              quo   <= '0;
              count <= CW'(XLEN);
              dz    <= 1'b0;
            end
          end
        end
        OPERATE: begin
          dvd   <= {dvd[XLEN-2:0], 1'b0};
          prem  <= prem_next;
          quo   <= quo_next;
          count <= count - CW'(1);
          if (last_step) begin
            quotient  <= quo_next;
            remainder <= prem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver pushes reference results,
// a negedge monitor pops and compares whenever done is seen.
module tb_seq_divider;

  localparam int unsigned XLEN = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            ready;
  logic            done;
  logic            dz;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  seq_divider #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .dz        (dz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic            dz;
    int unsigned     acc;   // edge number that accepted start
    int unsigned     lat;   // edges up to and including the one entering DONE
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  logic [XLEN-1:0] last_q, last_r;
  logic            last_dz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all ones / dividend.
  function automatic exp_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int unsigned acc);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = XLEN + 1;
    end
    e.acc = acc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done at cycle %0d: actual done=1 required done=0", cyc);
      end else begin
        e = sbq.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("dz", 32'(dz), 32'(e.dz));
        check("latency", cyc - e.acc + 1, e.lat);
        last_q = e.q; last_r = e.r; last_dz = e.dz;
      end
    end
  end

  // Returns at a negedge with ready high, or reports a timeout.
  task automatic wait_ready();
    int unsigned n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout at cycle %0d: actual ready=%b required 1", cyc, ready);
    end
  endtask

  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    wait_ready();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sbq.push_back(model(a, b, cyc));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [XLEN-1:0] a, b;
    int unsigned n;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dz", 32'(dz), 32'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("reset_prio_ready", 32'(ready), 32'd1);

    // Basic, extremes, divide-by-zero and recovery.
    issue(16'd100, 16'd7);
    wait_ready();
    repeat (3) @(negedge clk);
    check("hold_quotient", 32'(quotient), 32'd14);
    check("hold_remainder", 32'(remainder), 32'd2);
    issue(16'hFFFF, 16'd1);
    issue(16'd3, 16'd10);
    issue(16'd0, 16'd1);
    issue(16'd5, 16'd0);
    wait_ready();
    repeat (2) @(negedge clk);
    check("hold_dz", 32'(dz), 32'd1);
    issue(16'd9, 16'd3);

    // Start held high with churning operands during OPERATE.
    wait_ready();
    a = 16'd40000; b = 16'd123;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back(model(a, b, cyc));
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 40) begin
      check("busy_ready", 32'(ready), 32'd0);
      dividend = 16'($urandom); divisor = 16'($urandom);
      @(negedge clk);
      n++;
    end
    check("held_start_done_seen", 32'(done), 32'd1);
    a = 16'd777; b = 16'd25;
    dividend = a; divisor = b;
    @(negedge clk);
    check("idle_after_done_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    sbq.push_back(model(a, b, cyc));

    // Reset five cycles into OPERATE: everything clears, no done.
    issue(16'd1000, 16'd7);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    check("midreset_ready", 32'(ready), 32'd1);
    check("midreset_quotient", 32'(quotient), 32'd0);
    check("midreset_remainder", 32'(remainder), 32'd0);
    check("midreset_dz", 32'(dz), 32'd0);
    repeat (XLEN + 4) @(negedge clk);
    issue(16'd50, 16'd6);

    // Random operations, including zero and small divisors.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 30)) : 16'($urandom);
      issue(a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
